// File: rtl/kyber_serial_pkg.sv
// Shared types and elaboration-time helpers for the coefficient readout serializer.
// Optional macro SERIAL_PARITY_EN appends one even-parity bit to every frame.
package kyber_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // Smallest n with 2**n >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Serial frame length: all lane bits, plus the parity bit when enabled.
    function automatic int frame_bits(input int w, input int nch);
`ifdef SERIAL_PARITY_EN
        return w * nch + 1;
`else
        return w * nch;
`endif
    endfunction

endpackage

// File: rtl/serial_frame_fifo.sv
// Synchronous frame FIFO holding raw memory words until the shifter takes them.
// Write and read in the same cycle leave the count unchanged.
module serial_frame_fifo
    import kyber_serial_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage array: data needs no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/coeff_readout_serializer.sv
// Self-sequenced readout of coefficient memory to a 1-bit serial pin.
// Walks num_words addresses from base_addr, buffers frames, shifts them out MSB-first.
// Optional macro SERIAL_PARITY_EN appends an even-parity bit to each frame.
module coeff_readout_serializer
    import kyber_serial_pkg::*;
#(
    parameter int W       = 16,
    parameter int NCH     = 3,
    parameter int AW      = 11,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       num_words,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [NCH*W-1:0]  rd_data,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_frame,
    output logic              busy,
    output logic              done
);

    localparam int DW         = NCH * W;
    localparam int FRAME_BITS = frame_bits(W, NCH);
    localparam int IW         = clog2(FRAME_BITS);
    localparam int CW         = clog2(DEPTH) + 1;

    state_t               state;
    state_t               next_state;
    logic [AW:0]          remaining;
    logic [MEM_LAT-1:0]   ret_pipe;
    logic                 ret_valid;
    logic [CW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic [DW-1:0]        fifo_head;
    logic                 credit_ok;
    logic [FRAME_BITS-1:0] head_frame;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] cur_frame;
    logic                 active;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        cur_idx;
    logic                 accept;
    logic                 last_bit;

    // A read may issue only if its frame is guaranteed a FIFO slot on return.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
    assign ret_valid = ret_pipe[MEM_LAT-1];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and read strobe.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (remaining == '0) begin
                    next_state = DRAIN;
                end else begin
                    rd_en = credit_ok;
                end
            end
            DRAIN: begin
                if (fifo_empty && (inflight == '0) && !active) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address walker: loads on an accepted start, advances per issued read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_addr   <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && start) begin
            rd_addr   <= base_addr;
            remaining <= num_words;
        end else if (rd_en) begin
            rd_addr   <= rd_addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Return pipe tracks when each read's data lands; inflight counts unreturned reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ret_pipe <= '0;
            inflight <= '0;
        end else begin
            ret_pipe[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++) begin
                ret_pipe[i] <= ret_pipe[i-1];
            end
            case ({rd_en, ret_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    serial_frame_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (ret_valid),
        .wr_data (rd_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Reorder the head word so frame bit j is the j-th bit sent: lane 0 MSB first.
    always_comb begin
        head_frame = '0;
        for (int j = 0; j < DW; j++) begin
            head_frame[j] = fifo_head[(j / W) * W + (W - 1 - (j % W))];
        end
`ifdef SERIAL_PARITY_EN
        head_frame[DW] = ^fifo_head;
`endif
    end

    // Serial view: an idle shifter presents the FIFO head directly so no cycle is lost.
    always_comb begin
        cur_frame = active ? frame_q : head_frame;
        cur_idx   = active ? idx_q : '0;
        ser_valid = active | ~fifo_empty;
        ser_out   = ser_valid & cur_frame[cur_idx];
        ser_frame = ser_valid & (cur_idx == '0);
        accept    = ser_valid & ser_ready;
        last_bit  = (cur_idx == IW'(FRAME_BITS - 1));
        fifo_rd   = ~active & ~fifo_empty;
    end

    // Shifter: takes the head frame when idle, advances only on accepted bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            active  <= 1'b0;
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            if (fifo_rd) begin
                frame_q <= head_frame;
            end
            if (accept && last_bit) begin
                active <= 1'b0;
                idx_q  <= '0;
            end else begin
                active <= active | fifo_rd;
                idx_q  <= accept ? cur_idx + 1'b1 : cur_idx;
            end
        end
    end

endmodule

// File: tb/tb_coeff_readout_serializer.sv
// Self-checking bench for coeff_readout_serializer (W=16, NCH=3, AW=11, DEPTH=4, MEM_LAT=1).
// A queue model of the expected address stream and serial bit stream is built from
// memory contents on every accepted start; literal checks pin known frames and timing.
`timescale 1ns/1ps
module tb_coeff_readout_serializer;

    localparam int W       = 16;
    localparam int NCH     = 3;
    localparam int AW      = 11;
    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 1;
`ifdef SERIAL_PARITY_EN
    localparam int FB = 49;
`else
    localparam int FB = 48;
`endif
    localparam int PB = FB - 48;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [47:0]   rd_data = '0;
    logic          ser_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_frame;
    logic          busy;
    logic          done;

    coeff_readout_serializer #(
        .W(W), .NCH(NCH), .AW(AW), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ser_ready (ser_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_frame (ser_frame),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    int cycle = 0;
    always @(posedge CLK) cycle++;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_mode = 0;
    bit ready_toggle = 0;

    // Model state
    bit            exp_bits[$];
    bit            exp_first[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] ea;

    // Observation state
    logic [127:0]  cap_bits;
    logic [127:0]  cap_mask;
    int            cap_n;
    int            first_valid_cycle;
    int            done_count;
    int            done_cycle;
    int            rd_en_count;
    int            start_cycle;
    int            issued;
    int            begun;
    logic [AW-1:0] addr_log[8];
    int            addr_n;
    logic          prev_valid, prev_ready, prev_frame, prev_out;

    // Memory contents: lane k at [k*16 +: 16]
    function automatic logic [47:0] mem_word(input logic [AW-1:0] a);
        logic [15:0] a16;
        a16 = {5'b0, a};
        if (mem_mode == 1) return {32'h0, 15'h0, a[0]};
        return {a16 + 16'd2, a16 + 16'd1, a16};
    endfunction

    always @(posedge CLK) begin
        if (rd_en) rd_data <= mem_word(rd_addr);
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_model(input logic [AW-1:0] base, input int num);
        logic [AW-1:0] a;
        logic [47:0]   w;
        for (int i = 0; i < num; i++) begin
            a = base + AW'(i);
            w = mem_word(a);
            exp_addr.push_back(a);
            for (int k = 0; k < NCH; k++) begin
                for (int b = W - 1; b >= 0; b--) begin
                    exp_bits.push_back(w[k*W + b]);
                    exp_first.push_back(k == 0 && b == W - 1);
                end
            end
`ifdef SERIAL_PARITY_EN
            exp_bits.push_back(^w);
            exp_first.push_back(1'b0);
`endif
        end
    endtask

    task automatic clear_capture();
        cap_bits = '0;
        cap_mask = '0;
        cap_n = 0;
        first_valid_cycle = -1;
        done_count = 0;
        done_cycle = -1;
        rd_en_count = 0;
        addr_n = 0;
    endtask

    task automatic drive_ready();
        if (ready_toggle) ser_ready = ~ser_ready;
        else ser_ready = 1'b1;
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (RST) begin
            exp_bits.delete();
            exp_first.delete();
            exp_addr.delete();
            issued = 0;
            begun = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_frame = 1'b0;
            prev_out = 1'b0;
        end else begin
            if (rd_en) begin
                rd_en_count++;
                checkOutput("credit", 128'((issued - begun) < DEPTH), 1);
                issued++;
                if (exp_addr.size() == 0) begin
                    checkOutput("rd_en_unexpected", 1, 0);
                end else begin
                    ea = exp_addr.pop_front();
                    checkOutput("rd_addr", rd_addr, ea);
                end
                if (addr_n < 8) addr_log[addr_n] = rd_addr;
                addr_n++;
            end
            if (ser_valid) begin
                if (first_valid_cycle < 0) first_valid_cycle = cycle;
                if (prev_valid && !prev_ready) begin
                    checkOutput("hold_out", ser_out, prev_out);
                    checkOutput("hold_frame", ser_frame, prev_frame);
                end
                if (ser_frame && !(prev_valid && prev_frame && !prev_ready)) begun++;
                if (exp_bits.size() == 0) begin
                    checkOutput("ser_unexpected", 1, 0);
                end else begin
                    checkOutput("ser_out", ser_out, exp_bits[0]);
                    checkOutput("ser_frame", ser_frame, exp_first[0]);
                    if (ser_ready) begin
                        void'(exp_bits.pop_front());
                        void'(exp_first.pop_front());
                        cap_bits = {cap_bits[126:0], ser_out};
                        cap_mask = {cap_mask[126:0], ser_frame};
                        cap_n++;
                    end
                end
            end else if (ser_frame) begin
                checkOutput("frame_without_valid", ser_frame, 0);
            end
            if (done) begin
                done_count++;
                done_cycle = cycle;
                checkOutput("done_bits_left", 128'(exp_bits.size()), 0);
                checkOutput("done_reads_left", 128'(exp_addr.size()), 0);
            end
            prev_valid = ser_valid;
            prev_ready = ser_ready;
            prev_frame = ser_frame;
            prev_out = ser_out;
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] base, input int num);
        @(posedge CLK); #1;
        start = 1'b1;
        base_addr = base;
        num_words = (AW + 1)'(num);
        start_cycle = cycle;
        push_model(base, num);
        drive_ready();
        @(posedge CLK); #1;
        start = 1'b0;
        drive_ready();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            drive_ready();
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_count == 0 && n < limit) begin
            @(posedge CLK); #1;
            drive_ready();
            n++;
        end
        checkOutput("done_timeout", 128'(done_count > 0), 1);
        wait_cycles(4);
        checkOutput("done_once", 128'(done_count), 1);
        checkOutput("idle_after_done", busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_rd_en"}, rd_en, 0);
        checkOutput({tag, "_rd_addr"}, rd_addr, 0);
        checkOutput({tag, "_ser_valid"}, ser_valid, 0);
        checkOutput({tag, "_ser_out"}, ser_out, 0);
        checkOutput({tag, "_ser_frame"}, ser_frame, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        RST = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        ser_ready = 1'b1;
        clear_capture();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_quiet("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        $display("[TB] two frames from 0x010");
        clear_capture();
        applyStimulus(11'h010, 2);
        wait_done(1000);
        checkOutput("t1_latency", 128'(first_valid_cycle - start_cycle), 3);
        checkOutput("t1_bit_count", 128'(cap_n), 2 * FB);
`ifndef SERIAL_PARITY_EN
        checkOutput("t1_stream", cap_bits[95:0], 96'h0010_0011_0012_0011_0012_0013);
        checkOutput("t1_frame_marks", cap_mask[95:0], 96'h8000_0000_0000_8000_0000_0000);
`endif

        $display("[TB] address wrap from 0x7FE");
        clear_capture();
        applyStimulus(11'h7FE, 4);
        wait_done(2000);
        checkOutput("t2_addr_count", 128'(addr_n), 4);
        checkOutput("t2_addr0", addr_log[0], 11'h7FE);
        checkOutput("t2_addr1", addr_log[1], 11'h7FF);
        checkOutput("t2_addr2", addr_log[2], 11'h000);
        checkOutput("t2_addr3", addr_log[3], 11'h001);
        checkOutput("t2_bit_count", 128'(cap_n), 4 * FB);

        $display("[TB] zero-word readout");
        clear_capture();
        applyStimulus(11'h123, 0);
        wait_done(100);
        checkOutput("t3_no_reads", 128'(rd_en_count), 0);
        checkOutput("t3_no_valid", 128'(first_valid_cycle), 128'(-1));
        checkOutput("t3_done_delay", 128'(done_cycle - start_cycle), 3);

        $display("[TB] eight words with toggling ready and a dropped start");
        clear_capture();
        ready_toggle = 1'b1;
        applyStimulus(11'h100, 8);
        wait_cycles(10);
        start = 1'b1;
        base_addr = 11'h555;
        num_words = 12'd3;
        wait_cycles(1);
        start = 1'b0;
        wait_done(4000);
        ready_toggle = 1'b0;
        ser_ready = 1'b1;
        checkOutput("t4_reads", 128'(rd_en_count), 8);
        checkOutput("t4_bit_count", 128'(cap_n), 8 * FB);

        $display("[TB] reset in the middle of a frame");
        clear_capture();
        applyStimulus(11'h020, 5);
        n = 0;
        while (cap_n < 20 && n < 500) begin
            @(posedge CLK); #1;
            drive_ready();
            n++;
        end
        checkOutput("t5_reached_mid_frame", 128'(cap_n >= 20), 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_quiet("t5_after_reset");
        clear_capture();
        applyStimulus(11'h030, 1);
        wait_done(500);
        checkOutput("t5_bit_count", 128'(cap_n), FB);
        checkOutput("t5_first_frame", cap_bits[PB +: 48], 48'h0030_0031_0032);

`ifdef SERIAL_PARITY_EN
        $display("[TB] parity bits");
        clear_capture();
        mem_mode = 1;
        applyStimulus(11'h001, 2);
        wait_done(1000);
        mem_mode = 0;
        checkOutput("t6_bit_count", 128'(cap_n), 98);
        checkOutput("t6_frame0_data", cap_bits[97:50], 48'h0001_0000_0000);
        checkOutput("t6_frame0_parity", cap_bits[49], 1);
        checkOutput("t6_frame1_parity", cap_bits[0], 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
